// File: rtl/angle_stimulus_gen.sv
// Four-channel tone-burst generator with per-channel arrival delay, used to impose a known angle of arrival.
// Optional macro STIMGEN_REPEAT_EN: holding start at the last tick chains bursts without leaving RUN.
module angle_stimulus_gen #(
   parameter int unsigned HALF_PERIOD = 50,
   parameter int unsigned BURST_LEN   = 16,
   parameter int unsigned DELAY_W     = 8,
   parameter logic [7:0]  HIGH_LEVEL  = 8'd200,
   parameter logic [7:0]  LOW_LEVEL   = 8'd56,
   parameter logic [7:0]  IDLE_LEVEL  = 8'd128
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [DELAY_W-1:0] cfg_dx1,
   input  logic [DELAY_W-1:0] cfg_dx2,
   input  logic [DELAY_W-1:0] cfg_dy1,
   input  logic [DELAY_W-1:0] cfg_dy2,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [7:0]         x1,
   output logic [7:0]         x2,
   output logic [7:0]         y1,
   output logic [7:0]         y2
);

   localparam int unsigned NCH  = 4;
   localparam int unsigned B    = 2 * BURST_LEN * HALF_PERIOD;
   localparam int unsigned T_W  = DELAY_W + 1 + $clog2(B + 1);
   localparam int unsigned HP_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam int unsigned HC_W = $clog2(2 * BURST_LEN + 1);

   localparam logic [HP_W-1:0] HP_LAST  = HP_W'(HALF_PERIOD - 1);
   localparam logic [HC_W-1:0] HC_END   = HC_W'(2 * BURST_LEN);
   localparam logic [T_W-1:0]  B_TICKS  = T_W'(B);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t              state_q, state_d;
   logic [T_W-1:0]      t_q, t_d;
   logic [T_W-1:0]      last_q, last_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                cfg_ready_q, cfg_ready_d;
   logic [DELAY_W-1:0]  dly_q  [NCH];
   logic [DELAY_W-1:0]  dly_d  [NCH];
   logic [DELAY_W-1:0]  dcnt_q [NCH];
   logic [DELAY_W-1:0]  dcnt_d [NCH];
   logic [HP_W-1:0]     hp_q   [NCH];
   logic [HP_W-1:0]     hp_d   [NCH];
   logic [HC_W-1:0]     hc_q   [NCH];
   logic [HC_W-1:0]     hc_d   [NCH];
   logic [7:0]          smp_q  [NCH];
   logic [7:0]          smp_d  [NCH];

   logic [DELAY_W-1:0]  cfg_c  [NCH];
   logic [DELAY_W-1:0]  sel_c  [NCH];
   logic [DELAY_W-1:0]  max_c;
   logic                repeat_c;

   always_comb begin
      cfg_c[0] = cfg_dx1;
      cfg_c[1] = cfg_dx2;
      cfg_c[2] = cfg_dy1;
      cfg_c[3] = cfg_dy2;
   end

   // Delays that a burst starting this cycle will use: a same-cycle load takes priority.
   always_comb begin
      for (int i = 0; i < int'(NCH); i++) begin
         sel_c[i] = cfg_valid ? cfg_c[i] : dly_q[i];
      end
      max_c = sel_c[0];
      for (int i = 1; i < int'(NCH); i++) begin
         if (sel_c[i] > max_c) max_c = sel_c[i];
      end
   end

`ifdef STIMGEN_REPEAT_EN
   assign repeat_c = start;
`else
   assign repeat_c = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      last_d  = last_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dly_d   = dly_q;
      dcnt_d  = dcnt_q;
      hp_d    = hp_q;
      hc_d    = hc_q;
      smp_d   = smp_q;

      case (state_q)
         S_IDLE: begin
            if (cfg_valid) dly_d = cfg_c;
            if (start) begin
               state_d = S_RUN;
               busy_d  = 1'b1;
               t_d     = '0;
               last_d  = T_W'(max_c) + B_TICKS;
               for (int i = 0; i < int'(NCH); i++) begin
                  dcnt_d[i] = sel_c[i];
                  hp_d[i]   = '0;
                  hc_d[i]   = '0;
               end
            end
         end
         S_RUN: begin
            if (en) begin
               // Per channel: wait out the delay, then walk half-periods, alternating high/low.
               for (int i = 0; i < int'(NCH); i++) begin
                  if (dcnt_q[i] != '0) begin
                     smp_d[i]  = IDLE_LEVEL;
                     dcnt_d[i] = dcnt_q[i] - DELAY_W'(1);
                  end else if (hc_q[i] < HC_END) begin
                     smp_d[i] = hc_q[i][0] ? LOW_LEVEL : HIGH_LEVEL;
                     if (hp_q[i] == HP_LAST) begin
                        hp_d[i] = '0;
                        hc_d[i] = hc_q[i] + HC_W'(1);
                     end else begin
                        hp_d[i] = hp_q[i] + HP_W'(1);
                     end
                  end else begin
                     smp_d[i] = IDLE_LEVEL;
                  end
               end

               if (t_q == last_q) begin
                  done_d = 1'b1;
                  for (int i = 0; i < int'(NCH); i++) smp_d[i] = IDLE_LEVEL;
                  if (repeat_c) begin
                     t_d = '0;
                     for (int i = 0; i < int'(NCH); i++) begin
                        dcnt_d[i] = dly_q[i];
                        hp_d[i]   = '0;
                        hc_d[i]   = '0;
                     end
                  end else begin
                     state_d = S_IDLE;
                     busy_d  = 1'b0;
                  end
               end else begin
                  t_d = t_q + T_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      cfg_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         t_q         <= '0;
         last_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_ready_q <= 1'b1;
         for (int i = 0; i < int'(NCH); i++) begin
            dly_q[i]  <= '0;
            dcnt_q[i] <= '0;
            hp_q[i]   <= '0;
            hc_q[i]   <= '0;
            smp_q[i]  <= IDLE_LEVEL;
         end
      end else begin
         state_q     <= state_d;
         t_q         <= t_d;
         last_q      <= last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cfg_ready_q <= cfg_ready_d;
         dly_q       <= dly_d;
         dcnt_q      <= dcnt_d;
         hp_q        <= hp_d;
         hc_q        <= hc_d;
         smp_q       <= smp_d;
      end
   end

   assign cfg_ready = cfg_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign x1        = smp_q[0];
   assign x2        = smp_q[1];
   assign y1        = smp_q[2];
   assign y2        = smp_q[3];

endmodule
